// File: rtl/wb_sdr_arbiter.sv
// wb_sdr_arbiter: round-robin Wishbone arbiter with per-grant beat count and ack watchdog
module wb_sdr_arbiter #(
  parameter int NM = 2,
  parameter int AW = 26,
  parameter int DW = 32,
  parameter int TIMEOUT = 255,
  localparam int SW = DW / 8,
  localparam int IW = $clog2(NM),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [NM-1:0]      m_cyc_i,
  input  logic [NM-1:0]      m_stb_i,
  input  logic [NM-1:0]      m_we_i,
  input  logic [NM*AW-1:0]   m_addr_i,
  input  logic [NM*DW-1:0]   m_dat_i,
  input  logic [NM*SW-1:0]   m_sel_i,
  input  logic [NM*3-1:0]    m_cti_i,
  output logic [NM-1:0]      m_ack_o,
  output logic [DW-1:0]      m_dat_o,
  output logic               s_cyc_o,
  output logic               s_stb_o,
  output logic               s_we_o,
  output logic [AW-1:0]      s_addr_o,
  output logic [DW-1:0]      s_dat_o,
  output logic [SW-1:0]      s_sel_o,
  output logic [2:0]         s_cti_o,
  input  logic               s_ack_i,
  input  logic [DW-1:0]      s_dat_i,
  output logic [NM-1:0]      grant_o,
  output logic [15:0]        beat_cnt_o,
  output logic               timeout_o
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, win;
  logic [15:0] beat_q, beat_d;
  logic [TW-1:0] wd_q, wd_d;
  logic timeout_q, timeout_d, found, busy;
  logic [NM-1:0] req;
  assign busy = state_q == BUSY;
  assign req = m_cyc_i & m_stb_i;
  assign s_cyc_o = busy & m_cyc_i[idx_q];
  assign s_stb_o = s_cyc_o & m_stb_i[idx_q];
  assign s_we_o = busy & m_we_i[idx_q];
  assign s_addr_o = busy ? m_addr_i[idx_q*AW +: AW] : '0;
  assign s_dat_o = busy ? m_dat_i[idx_q*DW +: DW] : '0;
  assign s_sel_o = busy ? m_sel_i[idx_q*SW +: SW] : '0;
  assign s_cti_o = busy ? m_cti_i[idx_q*3 +: 3] : '0;
  assign m_ack_o = {NM{s_ack_i}} & grant_q & m_cyc_i;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;
  assign beat_cnt_o = beat_q;
  assign timeout_o = timeout_q;
  // first requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NM; k++) begin
      if (!found && req[(int'(ptr_q) + k) % NM]) begin
        found = 1'b1;
        win = IW'((int'(ptr_q) + k) % NM);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    beat_d = beat_q;
    if (!busy && found) begin
      state_d = BUSY;
      grant_d = '0;
      grant_d[win] = 1'b1;
      idx_d = win;
      beat_d = '0;
    end else if (busy && !m_cyc_i[idx_q]) begin
      state_d = IDLE;
      grant_d = '0;
      ptr_d = idx_q == IW'(NM - 1) ? '0 : idx_q + 1'b1;
    end else if (busy && s_ack_i && s_stb_o && !(&beat_q)) begin
      beat_d = beat_q + 1'b1;
    end
    wd_d = (s_stb_o && !s_ack_i) ? (wd_q == TW'(TIMEOUT) ? wd_q : wd_q + 1'b1) : '0;
    timeout_d = timeout_q | (wd_d == TW'(TIMEOUT));
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
      beat_q <= '0;
      wd_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      beat_q <= beat_d;
      wd_q <= wd_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: doc/wb_sdr_arbiter.md
# wb_sdr_arbiter

Round-robin Wishbone arbiter that shares the single Wishbone slave port of the SDRAM controller (`sdrc_top`) between NM independent bus masters. It sits between the masters and the controller's `wb_*` port in the system clock domain. It holds a grant for a master's entire `cyc` period, so classic and incrementing-burst (`cti`) cycles pass through unbroken. It also provides per-grant beat counting and an ack-timeout watchdog for verification visibility.

## Interface
- NM, 2: number of masters, 2..8
- AW, 26: Wishbone address width
- DW, 32: data width (SW = DW/8 byte selects)
- TIMEOUT, 255: cycles of `s_stb_o` without `s_ack_i` before `timeout_o` sets

Ports:
- wb_clk_i  in  1  system clock; all logic on its rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- m_cyc_i  in  NM  per-master cycle
- m_stb_i  in  NM  per-master strobe
- m_we_i  in  NM  per-master write enable
- m_addr_i  in  NM*AW  packed addresses; master i at [i*AW +: AW]
- m_dat_i  in  NM*DW  packed write data
- m_sel_i  in  NM*SW  packed byte selects
- m_cti_i  in  NM*3  packed cycle type
- m_ack_o  out  NM  per-master ack
- m_dat_o  out  DW  read data, broadcast to all masters
- s_cyc_o, s_stb_o, s_we_o  out  1  to controller
- s_addr_o  out  AW;  s_dat_o  out  DW;  s_sel_o  out  SW;  s_cti_o  out  3
- s_ack_i  in  1;  s_dat_i  in  DW  from controller
- grant_o  out  NM  one-hot registered grant; 0 when idle
- beat_cnt_o  out  16  acks in current/last grant, saturating
- timeout_o  out  1  sticky watchdog flag

## Operation
- States:
  - IDLE: `grant_o` = 0.
  - BUSY: exactly one `grant_o` bit is set.
- IDLE→BUSY:
  - Condition: any `m_cyc_i[i] & m_stb_i[i]` at the clock edge.
  - The winner is the first requester at or after `ptr`, scanning upward mod NM.
  - `grant_o` is loaded one-hot and `beat_cnt_o` is cleared.
- BUSY→IDLE:
  - Condition: the granted master's `m_cyc_i` is 0 at the clock edge.
  - `ptr` ← granted index + 1 (mod NM).
  - `grant_o` ← 0.
  - At least one IDLE cycle always separates two grants.
- No preemption: a master keeps its grant until it drops `cyc`, regardless of other requests.
- Slave-side signals are combinational muxes of the granted master:
  - s_cyc_o = |grant_o & m_cyc_i[g]
  - s_stb_o = |grant_o & m_cyc_i[g] & m_stb_i[g]
  - we/addr/dat/sel/cti are selected by the grant index; they are 0 when idle.
- m_ack_o[i] = s_ack_i & grant_o[i] & m_cyc_i[i]. An ack arriving while idle, or to a dropped master, is discarded.
- m_dat_o = s_dat_i unconditionally.
- beat_cnt_o:
  - Increments on each `s_ack_i & s_stb_o` in BUSY.
  - Saturates at 16'hFFFF.
  - Holds its value through IDLE until the next grant.
- Watchdog:
  - An internal counter counts consecutive cycles with `s_stb_o & !s_ack_i`.
  - It clears on ack or when `s_stb_o` is low.
  - When the count reaches TIMEOUT, `timeout_o` ← 1 and stays 1 until reset.
- Reset values: `grant_o` = 0, `ptr` = 0, `beat_cnt_o` = 0, `timeout_o` = 0, state = IDLE. All `s_*` outputs and `m_ack_o` are 0 in the cycle after the reset edge.
- Reset mid-burst: the grant drops at the reset edge and `s_cyc_o`/`s_stb_o` fall immediately. The master must restart its cycle.

## Timing
- Arbitration latency:
  - A request sampled at edge N gives `grant_o` valid after edge N.
  - `s_stb_o` is asserted in cycle N+1.
  - The minimum from a master's `stb` to the first possible ack is 1 cycle plus controller latency.
- Ack and read data pass combinationally, with zero added latency.
- Back-to-back grants: a release at edge R gives IDLE in cycle R+1. The next master's grant is set at edge R+1, so its `s_stb_o` appears in cycle R+2.
- Simultaneous requests are resolved solely by `ptr`. With NM=2 and continuous requests from both masters, grants alternate 0,1,0,1.
- A master raising `cyc` without `stb` does not win arbitration.

## Test plan
- Single master: M0 does a classic write to addr 0x100 with data 0xA5A5_5A5A, then a read.
  - `grant_o` = 2'b01 one cycle after the request.
  - The read returns 0xA5A5_5A5A.
  - `beat_cnt_o` = 1 per cycle.
  - `m_ack_o[1]` never asserts.
- Contention: M0 and M1 request at the same edge out of reset.
  - M0 wins first (`ptr` = 0).
  - M1 is granted exactly 2 cycles after M0 drops `cyc`.
  - A third simultaneous request round goes to M0 again.
- Burst pass-through: M1 issues an 8-beat incrementing burst (cti 3'b010 … 3'b111).
  - The burst is not interrupted by M0 requesting mid-burst.
  - `beat_cnt_o` = 8.
  - M0 is granted only after M1 drops `cyc`.
- Watchdog: force `s_ack_i` = 0 with `s_stb_o` held and TIMEOUT = 16.
  - `timeout_o` rises after 16 cycles.
  - It stays high after the ack resumes, until `wb_rst_i`.
- Reset mid-burst: assert `wb_rst_i` for 1 cycle during beat 3 of M0's burst.
  - The next cycle shows `grant_o` = 0, `s_cyc_o` = 0, `beat_cnt_o` = 0 and `ptr` = 0.
  - A subsequent request by M1 alone is granted normally.
